// File: rtl/reverse_bits_pipe.sv
// -----------------------------------------------------------------------------
// reverse_bits_pipe
//
// Two-stage pipelined bit/group permutation unit with valid/ready handshakes on
// both sides. It sustains one word per cycle and counts delivered words.
//
// Stage 1 captures din/din_mode on an input handshake. The permutation is
// combinational between the stages. Stage 2 holds the permuted word and its
// mode, and drives the output side.
//
// Modes (din_mode / dout_mode):
//   2'b00 pass-through
//   2'b01 full reverse           dout[i] = din[DATA_WIDTH-1-i]
//   2'b10 reverse inside groups  bit order flipped within each GROUP_WIDTH group
//   2'b11 reverse group order    groups swapped end-for-end, bits kept in place
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   din        input word                  din_mode   permutation select
//   din_valid  producer has a word         din_ready  word accepted this cycle
//   dout       permuted word               dout_mode  mode that produced dout
//   dout_valid dout holds a word           dout_ready consumer takes dout
//   xfer_count output handshakes since reset (wraps)
// -----------------------------------------------------------------------------
module reverse_bits_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int GROUP_WIDTH = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic [1:0]             din_mode,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic [1:0]             dout_mode,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  // Clamped group width keeps the index arithmetic below legal even when the
  // parameter check fires.
  localparam int GW         = (GROUP_WIDTH >= 1) ? GROUP_WIDTH : 1;
  localparam int NUM_GROUPS = DATA_WIDTH / GW;

  generate
    if (GROUP_WIDTH < 1) begin : g_bad_group
      $error("reverse_bits_pipe: GROUP_WIDTH (%0d) must be >= 1", GROUP_WIDTH);
    end else if ((DATA_WIDTH % GW) != 0) begin : g_bad_width
      $error("reverse_bits_pipe: DATA_WIDTH (%0d) is not a multiple of GROUP_WIDTH (%0d)",
             DATA_WIDTH, GROUP_WIDTH);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                   s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]  s1_data_q,  s1_data_d;
  logic [1:0]             s1_mode_q,  s1_mode_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]  s2_data_q,  s2_data_d;
  logic [1:0]             s2_mode_q,  s2_mode_d;

  logic [COUNT_WIDTH-1:0] count_q,    count_d;

  // Held low through reset and set by the first clock edge afterwards, so the
  // input side only opens once the block has seen a clean edge.
  logic                   live_q;

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic advance2;
  logic in_fire;
  logic out_fire;

  // Stage 2 can take a new word when it is empty or is being drained now.
  assign advance2  = !s2_valid_q || dout_ready;
  // No skid buffer: stage 1 only accepts when it is empty or moving forward.
  assign din_ready = live_q && (!s1_valid_q || advance2);
  assign in_fire   = din_valid && din_ready;
  assign out_fire  = s2_valid_q && dout_ready;

  // ---------------------------------------------------------------------------
  // Permutation network (pure wiring, one generate lane per output bit)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] perm_full;
  logic [DATA_WIDTH-1:0] perm_grp_bits;
  logic [DATA_WIDTH-1:0] perm_grp_order;
  logic [DATA_WIDTH-1:0] perm_word;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      localparam int GRP = gi / GW;   // group this output bit lives in
      localparam int OFS = gi % GW;   // bit position inside that group

      assign perm_full[gi]      = s1_data_q[DATA_WIDTH-1-gi];
      assign perm_grp_bits[gi]  = s1_data_q[GRP*GW + (GW-1-OFS)];
      assign perm_grp_order[gi] = s1_data_q[(NUM_GROUPS-1-GRP)*GW + OFS];
    end
  endgenerate

  always_comb begin
    perm_word = s1_data_q;
    case (s1_mode_q)
      2'b00:   perm_word = s1_data_q;
      2'b01:   perm_word = perm_full;
      2'b10:   perm_word = perm_grp_bits;
      2'b11:   perm_word = perm_grp_order;
      default: perm_word = s1_data_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_mode_d  = s2_mode_q;
    count_d    = count_q;

    // Stage 1: a new word overrides the "moved on" case because both can
    // happen in the same cycle without a bubble.
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = din;
      s1_mode_d  = din_mode;
    end else if (advance2) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2: the payload only updates when a real word arrives, so a
    // drained stage keeps its last value rather than picking up stale data.
    if (advance2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = perm_word;
        s2_mode_d = s1_mode_q;
      end
    end

    if (out_fire) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 2'b00;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mode_q  <= 2'b00;
      count_q    <= '0;
    end else begin
      live_q     <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_mode_q  <= s2_mode_d;
      count_q    <= count_d;
    end
  end

  assign dout       = s2_data_q;
  assign dout_mode  = s2_mode_q;
  assign dout_valid = s2_valid_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_reverse_bits_pipe.sv
// -----------------------------------------------------------------------------
// tb_reverse_bits_pipe
//
// Directed and randomised stimulus for reverse_bits_pipe. A queue-based model
// tracks every accepted word, its permuted value and the edge it was accepted
// on; a monitor compares both DUT instances against it on every falling edge.
// A second instance with a 4-bit counter shares all inputs to exercise wrap.
// -----------------------------------------------------------------------------
module tb_reverse_bits_pipe;

  localparam int W  = 32;
  localparam int G  = 8;
  localparam int NG = W / G;

  logic          clk;
  logic          rst;
  logic [W-1:0]  din;
  logic [1:0]    din_mode;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  dout;
  logic [1:0]    dout_mode;
  logic          dout_valid;
  logic          dout_ready;
  logic [15:0]   xfer_count;

  logic          din_ready_c;
  logic [W-1:0]  dout_c;
  logic [1:0]    dout_mode_c;
  logic          dout_valid_c;
  logic [3:0]    xfer_count_c;

  reverse_bits_pipe #(.DATA_WIDTH(W), .GROUP_WIDTH(G), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_mode(din_mode), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_mode(dout_mode),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .xfer_count(xfer_count)
  );

  reverse_bits_pipe #(.DATA_WIDTH(W), .GROUP_WIDTH(G), .COUNT_WIDTH(4)) u_cnt (
    .clk(clk), .rst(rst), .din(din), .din_mode(din_mode), .din_valid(din_valid),
    .din_ready(din_ready_c), .dout(dout_c), .dout_mode(dout_mode_c),
    .dout_valid(dout_valid_c), .dout_ready(dout_ready), .xfer_count(xfer_count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference permutation written straight from the mode definitions.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    r = d;
    case (m)
      2'b01: for (int i = 0; i < W; i++) r[i] = d[W-1-i];
      2'b10: for (int g = 0; g < NG; g++)
               for (int j = 0; j < G; j++) r[g*G+j] = d[g*G+G-1-j];
      2'b11: for (int g = 0; g < NG; g++) r[g*G +: G] = d[(NG-1-g)*G +: G];
      default: r = d;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Model state and monitor
  // ---------------------------------------------------------------------------
  logic [W-1:0] q_data[$];
  logic [1:0]   q_mode[$];
  int           q_acc[$];
  logic [W-1:0] out_log[$];
  int           out_edge[$];
  int           m_cnt     = 0;
  int           edge_now  = 0;
  bit           seen_edge = 0;

  initial begin : monitor
    bit           hs_in, hs_out, exp_valid, exp_ready;
    logic [W-1:0] pend_d;
    logic [1:0]   pend_m;
    forever begin
      @(negedge clk);
      hs_in  = 0;
      hs_out = 0;
      if (!rst) begin
        q_data.delete(); q_mode.delete(); q_acc.delete();
        m_cnt     = 0;
        seen_edge = 0;
        ck("rst_dout_valid", dout_valid, 0);
        ck("rst_dout", dout, 0);
        ck("rst_dout_mode", dout_mode, 0);
        ck("rst_xfer_count", xfer_count, 0);
        ck("rst_din_ready", din_ready, 0);
        ck("rst_xfer_count_c", xfer_count_c, 0);
      end else begin
        exp_ready = seen_edge && (q_data.size() < 2 || dout_ready);
        exp_valid = (q_data.size() > 0) && (edge_now > q_acc[0]);
        ck("din_ready", din_ready, exp_ready);
        ck("din_ready_c", din_ready_c, exp_ready);
        ck("dout_valid", dout_valid, exp_valid);
        ck("dout_valid_c", dout_valid_c, exp_valid);
        if (exp_valid) begin
          ck("dout", dout, q_data[0]);
          ck("dout_mode", dout_mode, q_mode[0]);
          ck("dout_c", dout_c, q_data[0]);
        end
        ck("xfer_count", xfer_count, 64'(m_cnt[15:0]));
        ck("xfer_count_c", xfer_count_c, 64'(m_cnt[3:0]));
        hs_in  = din_valid && din_ready;
        hs_out = dout_valid && dout_ready;
        pend_d = din;
        pend_m = din_mode;
      end
      @(posedge clk);
      if (rst) begin
        edge_now++;
        seen_edge = 1;
        if (hs_out && q_data.size() > 0) begin
          m_cnt++;
          $display("xfer %0d: dout=%h mode=%0d", m_cnt, q_data[0], q_mode[0]);
          out_log.push_back(q_data[0]);
          out_edge.push_back(edge_now);
          void'(q_data.pop_front());
          void'(q_mode.pop_front());
          void'(q_acc.pop_front());
        end
        if (hs_in) begin
          q_data.push_back(model(pend_d, pend_m));
          q_mode.push_back(pend_m);
          q_acc.push_back(edge_now);
        end
      end
    end
  end

  // Random consumer backpressure, enabled only for the soak phase.
  bit rand_ready_en = 0;
  initial begin : rand_ready
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready_en) dout_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Present a word and hold it until accepted. Call at posedge+2; returns at
  // posedge+2 after the handshake edge with din_valid still high.
  task automatic push(input logic [W-1:0] d, input logic [1:0] m);
    bit acc;
    din       = d;
    din_mode  = m;
    din_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #2;
      if (acc) return;
    end
    ck("push_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait (bounded) until the model has counted `target` deliveries, then pin
  // both counters to hand-computed values.
  task automatic wait_count(input int target, input logic [3:0] exp_c);
    bit hit;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (m_cnt == target) begin hit = 1; break; end
    end
    ck("count_reached", hit, 1);
    ck("wrap_count_c", xfer_count_c, exp_c);
    ck("wrap_count", xfer_count, target);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    rst        = 1'b0;
    din        = '0;
    din_mode   = 2'b00;
    din_valid  = 1'b0;
    dout_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    ck("reset_dout_valid", dout_valid, 0);
    ck("reset_xfer_count", xfer_count, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    ck("ready_before_first_edge", din_ready, 0);
    @(posedge clk); #1;
    ck("ready_after_first_edge", din_ready, 1);
    #1;

    // Single mode-01 word and its latency
    out_log.delete();
    push(32'h0000_0001, 2'b01);
    din_valid = 1'b0;
    @(negedge clk);
    ck("t1_valid_early", dout_valid, 0);
    @(negedge clk);
    ck("t1_valid", dout_valid, 1);
    ck("t1_dout", dout, 32'h8000_0000);
    ck("t1_mode", dout_mode, 2'b01);
    @(posedge clk); #1;
    ck("t1_count", xfer_count, 1);
    #1;

    // Back-to-back words
    out_log.delete(); out_edge.delete();
    push(32'h0000_0001, 2'b10);
    push(32'h1234_5678, 2'b11);
    push(32'hDEAD_BEEF, 2'b00);
    idle(5);
    ck("b2b_n", out_log.size(), 3);
    if (out_log.size() == 3) begin
      ck("b2b_w0", out_log[0], 32'h0000_0080);
      ck("b2b_w1", out_log[1], 32'h7856_3412);
      ck("b2b_w2", out_log[2], 32'hDEAD_BEEF);
      ck("b2b_gap01", out_edge[1] - out_edge[0], 1);
      ck("b2b_gap12", out_edge[2] - out_edge[1], 1);
    end

    // Backpressure: two words held, third refused, then drained in order
    out_log.delete();
    base       = m_cnt;
    dout_ready = 1'b0;
    push(32'd1, 2'b00);
    push(32'd2, 2'b00);
    din = 32'd3; din_mode = 2'b00; din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ck("bp_ready_low", din_ready, 0);
      ck("bp_dout_stable", dout, 1);
      ck("bp_dout_valid", dout_valid, 1);
    end
    @(posedge clk); #2;
    dout_ready = 1'b1;
    push(32'd3, 2'b00);
    idle(5);
    ck("bp_n", out_log.size(), 3);
    if (out_log.size() == 3) begin
      ck("bp_w0", out_log[0], 1);
      ck("bp_w1", out_log[1], 2);
      ck("bp_w2", out_log[2], 3);
    end
    ck("bp_count", xfer_count, base + 3);

    // Walking one in mode 01
    out_log.delete();
    for (int i = 0; i < W; i++) push(32'd1 << i, 2'b01);
    idle(5);
    ck("walk_n", out_log.size(), W);
    if (out_log.size() == W)
      for (int i = 0; i < W; i++) ck("walk", out_log[i], 32'h8000_0000 >> i);

    // Random soak: all modes, random gaps and random backpressure
    rand_ready_en = 1;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      push($urandom, 2'($urandom_range(0, 3)));
    end
    rand_ready_en = 0;
    @(posedge clk); #2;
    dout_ready = 1'b1;
    idle(6);
    ck("soak_drained", dout_valid, 0);

    // Reset with two words in flight
    dout_ready = 1'b0;
    push(32'hA5A5_0001, 2'b01);
    push(32'h0F0F_0002, 2'b10);
    din_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    ck("mid_rst_valid", dout_valid, 0);
    ck("mid_rst_count", xfer_count, 0);
    ck("mid_rst_ready", din_ready, 0);
    ck("mid_rst_dout", dout, 0);
    dout_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    push(32'h0000_00F0, 2'b10);
    din_valid = 1'b0;
    @(negedge clk);
    ck("post_rst_valid_early", dout_valid, 0);
    @(negedge clk);
    ck("post_rst_valid", dout_valid, 1);
    ck("post_rst_dout", dout, 32'h0000_000F);
    @(posedge clk); #2;

    // Counter wrap on the 4-bit instance: 17 deliveries since reset
    fork
      begin
        for (int k = 0; k < 16; k++) push(32'(k), 2'b00);
        din_valid = 1'b0;
      end
      begin
        wait_count(15, 4'd15);
        wait_count(16, 4'd0);
        wait_count(17, 4'd1);
      end
    join
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
